alu_div_sequencer: RTL

Multi-cycle unsigned integer divider that borrows the processor's shared add/subtract ALU rather than carrying its own subtractor. It runs a restoring-division loop of one ALU subtract per quotient bit and commits or discards each step based on the ALU borrow flag. It sits beside the execute stage; `alu_own` tells the top-level operand mux when the sequencer is driving the ALU.

---
 rtl/alu_div_pkg.sv | 6 +
 rtl/alu_div_sequencer_if.sv | 30 +++
 rtl/div_step.sv | 17 +
 rtl/alu_div_sequencer.sv | 122 ++++++++++++
 4 files changed

// File: rtl/alu_div_pkg.sv
// Shared types and ALU op encodings for the ALU-borrowing divider.
package alu_div_pkg;
  typedef enum logic [1:0] {IDLE, CMP, RUN, DONE} div_state_t;
  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;
endpackage

// File: rtl/alu_div_sequencer_if.sv
// Divider request/result handshake plus the shared-ALU operand/result bus.
interface alu_div_sequencer_if #(parameter int N = 32);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         ready;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         alu_own;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic         alu_ctrl;
  logic [N-1:0] alu_y;
  logic         alu_cb;

  // master = execute-stage side (issues requests, hosts the ALU)
  modport master (
    output start, dividend, divisor, alu_y, alu_cb,
    input  ready, busy, done, div_zero, quotient, remainder,
           alu_own, alu_a, alu_b, alu_ctrl
  );
  modport slave (
    input  start, dividend, divisor, alu_y, alu_cb,
    output ready, busy, done, div_zero, quotient, remainder,
           alu_own, alu_a, alu_b, alu_ctrl
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: forms the shifted trial and picks the ALU
// difference or the restored trial depending on the borrow.
module div_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] rem,
  input  logic         q_msb,
  input  logic [N-1:0] alu_y,
  input  logic         alu_cb,
  output logic [N-1:0] trial,
  output logic [N-1:0] rem_nxt,
  output logic         q_bit
);
  assign trial   = {rem[N-2:0], q_msb};
  assign q_bit   = ~alu_cb;
  assign rem_nxt = alu_cb ? trial : alu_y;
endmodule

// File: rtl/alu_div_sequencer.sv
// Multi-cycle unsigned restoring divider driving the shared ALU.
// Optional macro ALU_DIV_EARLY_OUT_EN adds a one-cycle dividend<divisor early out.
module alu_div_sequencer
  import alu_div_pkg::*;
#(
  parameter int n = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_div_sequencer_if.slave bus
);
  localparam int CW = (n > 2) ? $clog2(n) : 1;

  div_state_t    state, state_nxt;
  logic [n-1:0]  q, rem, dvs;
  logic [CW-1:0] cnt;
  logic          div_zero;
  logic [n-1:0]  trial, rem_nxt;
  logic          q_bit;
  logic          alu_own, alu_ctrl;
  logic [n-1:0]  alu_a, alu_b;

  div_step #(.N(n)) u_step (
    .rem    (rem),
    .q_msb  (q[n-1]),
    .alu_y  (bus.alu_y),
    .alu_cb (bus.alu_cb),
    .trial  (trial),
    .rem_nxt(rem_nxt),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    alu_own   = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_ctrl  = ALU_OP_ADD;
    unique case (state)
      IDLE: if (bus.start) begin
        if (bus.divisor == '0) state_nxt = DONE;
`ifdef ALU_DIV_EARLY_OUT_EN
        else                   state_nxt = CMP;
`else
        else                   state_nxt = RUN;
`endif
      end
`ifdef ALU_DIV_EARLY_OUT_EN
      CMP: begin
        alu_own   = 1'b1;
        alu_a     = q;
        alu_b     = dvs;
        alu_ctrl  = ALU_OP_SUB;
        state_nxt = bus.alu_cb ? DONE : RUN;
      end
`endif
      RUN: begin
        alu_own  = 1'b1;
        alu_a    = trial;
        alu_b    = dvs;
        alu_ctrl = ALU_OP_SUB;
        if (cnt == CW'(n - 1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // q doubles as the dividend shift register; results are final on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= '0;
      rem      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      div_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.start) begin
          dvs      <= bus.divisor;
          cnt      <= '0;
          div_zero <= (bus.divisor == '0);
          if (bus.divisor == '0) begin
            q   <= '1;
            rem <= bus.dividend;
          end else begin
            q   <= bus.dividend;
            rem <= '0;
          end
        end
`ifdef ALU_DIV_EARLY_OUT_EN
        CMP: if (bus.alu_cb) begin
          q   <= '0;
          rem <= q;
        end
`endif
        RUN: begin
          rem <= rem_nxt;
          q   <= {q[n-2:0], q_bit};
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.ready     = (state == IDLE);
  assign bus.busy      = (state != IDLE) && (state != DONE);
  assign bus.done      = (state == DONE);
  assign bus.div_zero  = div_zero;
  assign bus.quotient  = q;
  assign bus.remainder = rem;
  assign bus.alu_own   = alu_own;
  assign bus.alu_a     = alu_a;
  assign bus.alu_b     = alu_b;
  assign bus.alu_ctrl  = alu_ctrl;
endmodule
